// File: rtl/toggle_event_receiver_pkg.sv
// -----------------------------------------------------------------------------
// toggle_event_pkg
//   Shared constants and types for the toggle event receiver.
//   SYNC_STAGES_MIN      smallest legal synchroniser depth
//   SYNC_STAGES_DEFAULT  default synchroniser depth
//   COUNT_WIDTH_DEFAULT  default width of the pending-event counter
//   toggle_rx_state_e    receiver FSM states (WARMUP, RUN)
// -----------------------------------------------------------------------------
package toggle_event_pkg;

    localparam int SYNC_STAGES_MIN     = 2;
    localparam int SYNC_STAGES_DEFAULT = 2;
    localparam int COUNT_WIDTH_DEFAULT = 4;

    typedef enum logic {
        WARMUP = 1'b0,
        RUN    = 1'b1
    } toggle_rx_state_e;

endpackage

// File: rtl/toggle_event_receiver_if.sv
// -----------------------------------------------------------------------------
// toggle_event_receiver_if
//   Event delivery bundle between the receiver (master) and local consumer
//   logic (slave).
//   eventValid     master->slave  at least one event pending
//   eventReady     slave->master  consumer takes one event when valid&&ready
//   pendingCount   master->slave  number of events pending
//   overflow       master->slave  sticky: an event was lost at saturation
//   clearOverflow  slave->master  synchronous clear of overflow
//   toggleAck      master->slave  acknowledge toggle (0 unless ack enabled)
// -----------------------------------------------------------------------------
interface toggle_event_receiver_if
    import toggle_event_pkg::*;
#(
    parameter int COUNT_WIDTH = COUNT_WIDTH_DEFAULT
);
    logic                   eventValid;
    logic                   eventReady;
    logic [COUNT_WIDTH-1:0] pendingCount;
    logic                   overflow;
    logic                   clearOverflow;
    logic                   toggleAck;

    modport master (
        output eventValid,
        output pendingCount,
        output overflow,
        output toggleAck,
        input  eventReady,
        input  clearOverflow
    );

    modport slave (
        input  eventValid,
        input  pendingCount,
        input  overflow,
        input  toggleAck,
        output eventReady,
        output clearOverflow
    );
endinterface

// File: rtl/toggle_event_receiver_sync.sv
// -----------------------------------------------------------------------------
// toggle_synchronizer
//   SYNC_STAGES-deep flop chain bringing the asynchronous toggle line into the
//   clock domain. All stages reset to 0 asynchronously.
//   clock      in   core clock
//   reset      in   asynchronous active-low reset
//   toggleIn   in   asynchronous toggle line
//   syncLevel  out  synchronised level (last stage of the chain)
// -----------------------------------------------------------------------------
module toggle_synchronizer
    import toggle_event_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic toggleIn,
    output logic syncLevel
);

    generate
        if (SYNC_STAGES < SYNC_STAGES_MIN) begin : g_bad_depth
            $error("toggle_synchronizer: SYNC_STAGES must be >= 2");
        end
    endgenerate

    logic [SYNC_STAGES-1:0] r_sync;

    // Stage 0 samples the asynchronous line; later stages resolve metastability.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], toggleIn};
        end
    end

    assign syncLevel = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/toggle_event_receiver.sv
// -----------------------------------------------------------------------------
// toggle_event_receiver
//   Receiving end of a toggle-encoded event link. Each level change of
//   toggleIn is one event. The line is synchronised, transitions are detected
//   and counted, and events are handed out one per valid/ready transfer.
//   clock     in   core clock
//   reset     in   asynchronous active-low reset
//   toggleIn  in   asynchronous toggle line from the sender's toggle flop
//   evt       master modport of toggle_event_receiver_if (valid/ready,
//             pendingCount, overflow/clearOverflow, toggleAck)
// Configuration macro: TOGGLE_EVENT_RECEIVER_ACK_EN
//   defined   toggleAck inverts on every pop (2-phase acknowledge)
//   undefined toggleAck is tied low
// -----------------------------------------------------------------------------
module toggle_event_receiver
    import toggle_event_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT,
    parameter int COUNT_WIDTH = COUNT_WIDTH_DEFAULT
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    toggleIn,
    toggle_event_receiver_if.master evt
);

    localparam int WARM_W = $clog2(SYNC_STAGES + 1);
    localparam logic [WARM_W-1:0]      WARM_LAST = WARM_W'(SYNC_STAGES);
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

    toggle_rx_state_e       r_state;
    toggle_rx_state_e       w_state_next;
    logic [WARM_W-1:0]      r_warm;
    logic [WARM_W-1:0]      w_warm_next;
    logic                   r_prev;
    logic [COUNT_WIDTH-1:0] r_count;
    logic [COUNT_WIDTH-1:0] w_count_next;
    logic                   r_overflow;
    logic                   w_overflow_next;
    logic                   w_sync;
    logic                   w_detect;
    logic                   w_valid;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_ovf_set;

    toggle_synchronizer #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clock     (clock),
        .reset     (reset),
        .toggleIn  (toggleIn),
        .syncLevel (w_sync)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= WARMUP;
            r_warm  <= '0;
        end else begin
            r_state <= w_state_next;
            r_warm  <= w_warm_next;
        end
    end

    // ---------------- FSM: next state / detect ----------------
    // WARMUP lasts SYNC_STAGES+1 cycles so the level present at reset release
    // has reached r_prev before any comparison is made; that level is the
    // baseline and produces no event.
    always_comb begin
        w_state_next = r_state;
        w_warm_next  = r_warm;
        w_detect     = 1'b0;
        case (r_state)
            WARMUP: begin
                if (r_warm == WARM_LAST) begin
                    w_state_next = RUN;
                end else begin
                    w_warm_next = r_warm + WARM_W'(1);
                end
            end
            RUN: begin
                w_detect = w_sync ^ r_prev;
            end
            default: begin
                w_state_next = WARMUP;
            end
        endcase
    end

    // Previous synchronised level tracks the chain in every state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= w_sync;
        end
    end

    // ---------------- pending counter and overflow ----------------
    assign w_valid   = (r_count != '0);
    assign w_pop     = w_valid & evt.eventReady;
    assign w_full    = (r_count == COUNT_MAX);
    // An event lost only when it cannot be absorbed by a simultaneous pop.
    assign w_ovf_set = w_detect & ~w_pop & w_full;

    always_comb begin
        w_count_next = r_count;
        if (w_detect && !w_pop && !w_full) begin
            w_count_next = r_count + COUNT_WIDTH'(1);
        end else if (w_pop && !w_detect) begin
            w_count_next = r_count - COUNT_WIDTH'(1);
        end
    end

    // Set has priority over clear when both happen in the same cycle.
    assign w_overflow_next = (r_overflow & ~evt.clearOverflow) | w_ovf_set;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_count    <= w_count_next;
            r_overflow <= w_overflow_next;
        end
    end

    // ---------------- acknowledge toggle ----------------
`ifdef TOGGLE_EVENT_RECEIVER_ACK_EN
    logic r_ack;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ack <= 1'b0;
        end else if (w_pop) begin
            r_ack <= ~r_ack;
        end
    end

    assign evt.toggleAck = r_ack;
`else
    assign evt.toggleAck = 1'b0;
`endif

    assign evt.eventValid   = w_valid;
    assign evt.pendingCount = r_count;
    assign evt.overflow     = r_overflow;

endmodule

// File: tb/tb_toggle_event_receiver.sv
// -----------------------------------------------------------------------------
// tb_toggle_event_receiver
//   Self-checking bench for toggle_event_receiver. The reference model treats
//   each toggle as an event that becomes visible SYNC_STAGES edges after the
//   edge that first samples it, and keeps pending/overflow/ack as plain
//   counters. Toggles present at the first edge after reset release form the
//   baseline and are not events.
// -----------------------------------------------------------------------------
module tb_toggle_event_receiver;
    import toggle_event_pkg::*;

    localparam int S = 2;
    localparam int W = 4;
    localparam logic [W-1:0] MAXC = '1;
`ifdef TOGGLE_EVENT_RECEIVER_ACK_EN
    localparam bit ACK_EN = 1'b1;
`else
    localparam bit ACK_EN = 1'b0;
`endif

    logic clk       = 1'b0;
    logic rst_n     = 1'b1;
    logic toggle_in = 1'b0;
    logic ev_ready  = 1'b0;
    logic clr_ovf   = 1'b0;

    always #5 clk = ~clk;

    toggle_event_receiver_if #(.COUNT_WIDTH(W)) evt_if ();
    assign evt_if.eventReady    = ev_ready;
    assign evt_if.clearOverflow = clr_ovf;

    toggle_event_receiver #(
        .SYNC_STAGES (S),
        .COUNT_WIDTH (W)
    ) dut (
        .clock    (clk),
        .reset    (rst_n),
        .toggleIn (toggle_in),
        .evt      (evt_if)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    logic [W-1:0] m_count;
    logic         m_ovf;
    logic         m_ack;
    logic         m_last;
    int           edge_n;
    int           arr_q[$];

    task automatic model_reset();
        m_count = '0;
        m_ovf   = 1'b0;
        m_ack   = 1'b0;
        edge_n  = 0;
        arr_q.delete();
    endtask

    // Called right after each active edge with the inputs that edge sampled.
    task automatic model_edge();
        bit arr, pop;
        edge_n++;
        arr = 1'b0;
        if (arr_q.size() > 0 && arr_q[0] == edge_n) begin
            arr = 1'b1;
            void'(arr_q.pop_front());
        end
        if (edge_n >= 2 && toggle_in != m_last) arr_q.push_back(edge_n + S);
        m_last = toggle_in;
        pop = (m_count != 0) && ev_ready;
        if (clr_ovf) m_ovf = 1'b0;
        if (arr && !pop && m_count == MAXC) m_ovf = 1'b1;
        if (arr && !pop && m_count != MAXC) m_count = m_count + 1'b1;
        else if (pop && !arr) m_count = m_count - 1'b1;
        if (pop && ACK_EN) m_ack = ~m_ack;
    endtask

    // One clock: drive at negedge, model at posedge, return at next negedge.
    task automatic cycle(input bit flip, input bit rdy, input bit clr);
        if (flip) toggle_in = ~toggle_in;
        ev_ready = rdy;
        clr_ovf  = clr;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    // Reset with a chosen toggle level; returns at a negedge just after release.
    task automatic apply_reset(input logic lvl);
        @(negedge clk);
        rst_n     = 1'b0;
        toggle_in = lvl;
        ev_ready  = 1'b0;
        clr_ovf   = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic warm();
        repeat (S + 2) cycle(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        n_checks++; if (evt_if.pendingCount !== '0) begin n_fail++; $display("FAIL rst_count: got %0d expected 0", evt_if.pendingCount); end
        n_checks++; if (evt_if.eventValid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b expected 0", evt_if.eventValid); end
        n_checks++; if (evt_if.overflow !== 1'b0) begin n_fail++; $display("FAIL rst_ovf: got %b expected 0", evt_if.overflow); end
        n_checks++; if (evt_if.toggleAck !== 1'b0) begin n_fail++; $display("FAIL rst_ack: got %b expected 0", evt_if.toggleAck); end
        apply_reset(1'b1);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b0, 1'b0);
            n_checks++; if (evt_if.pendingCount !== '0) begin n_fail++; $display("FAIL baseline_count: got %0d expected 0", evt_if.pendingCount); end
            n_checks++; if (evt_if.eventValid !== 1'b0) begin n_fail++; $display("FAIL baseline_valid: got %b expected 0", evt_if.eventValid); end
        end
        $display("test_reset done");
    endtask

    task automatic test_latency();
        int rise = 0;
        int ncyc = 0;
        apply_reset(1'b0);
        warm();
        for (int t = 0; t < 3; t++) begin
            for (int c = 0; c < 4; c++) begin
                cycle(c == 0, 1'b0, 1'b0);
                ncyc++;
                if (t == 0 && rise == 0 && evt_if.eventValid === 1'b1) rise = ncyc;
                n_checks++; if (evt_if.pendingCount !== m_count) begin n_fail++; $display("FAIL lat_count: got %0d expected %0d", evt_if.pendingCount, m_count); end
                n_checks++; if (evt_if.eventValid !== (m_count != 0)) begin n_fail++; $display("FAIL lat_valid: got %b expected %b", evt_if.eventValid, m_count != 0); end
            end
        end
        repeat (S + 1) cycle(1'b0, 1'b0, 1'b0);
        n_checks++; if (rise != S + 1) begin n_fail++; $display("FAIL lat_first_rise: got %0d edges expected %0d", rise, S + 1); end
        n_checks++; if (evt_if.pendingCount !== 4'd3) begin n_fail++; $display("FAIL lat_total: got %0d expected 3", evt_if.pendingCount); end
        $display("test_latency done");
    endtask

    task automatic test_collide();
        apply_reset(1'b0);
        warm();
        cycle(1'b1, 1'b0, 1'b0);
        repeat (S + 1) cycle(1'b0, 1'b0, 1'b0);
        n_checks++; if (evt_if.pendingCount !== 4'd1) begin n_fail++; $display("FAIL col_pre: got %0d expected 1", evt_if.pendingCount); end
        cycle(1'b1, 1'b0, 1'b0);
        repeat (S - 1) cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        n_checks++; if (evt_if.pendingCount !== 4'd1) begin n_fail++; $display("FAIL col_count: got %0d expected 1", evt_if.pendingCount); end
        n_checks++; if (evt_if.eventValid !== 1'b1) begin n_fail++; $display("FAIL col_valid: got %b expected 1", evt_if.eventValid); end
        n_checks++; if (evt_if.pendingCount !== m_count) begin n_fail++; $display("FAIL col_model: got %0d expected %0d", evt_if.pendingCount, m_count); end
        $display("test_collide done");
    endtask

    task automatic test_overflow();
        apply_reset(1'b0);
        warm();
        for (int t = 0; t < 16; t++) begin
            for (int c = 0; c < 4; c++) begin
                cycle(c == 0, 1'b0, 1'b0);
                n_checks++; if (evt_if.pendingCount !== m_count) begin n_fail++; $display("FAIL ovf_count: got %0d expected %0d", evt_if.pendingCount, m_count); end
                n_checks++; if (evt_if.overflow !== m_ovf) begin n_fail++; $display("FAIL ovf_flag: got %b expected %b", evt_if.overflow, m_ovf); end
            end
        end
        repeat (S + 1) cycle(1'b0, 1'b0, 1'b0);
        n_checks++; if (evt_if.pendingCount !== 4'd15) begin n_fail++; $display("FAIL ovf_sat: got %0d expected 15", evt_if.pendingCount); end
        n_checks++; if (evt_if.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b expected 1", evt_if.overflow); end
        cycle(1'b0, 1'b0, 1'b1);
        n_checks++; if (evt_if.overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b expected 0", evt_if.overflow); end
        n_checks++; if (evt_if.pendingCount !== 4'd15) begin n_fail++; $display("FAIL ovf_clear_count: got %0d expected 15", evt_if.pendingCount); end
        // event arrives at full while clear is pulsed: set wins
        cycle(1'b1, 1'b0, 1'b0);
        repeat (S - 1) cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        n_checks++; if (evt_if.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set_wins: got %b expected 1", evt_if.overflow); end
        // event arrives at full together with a pop: no loss
        cycle(1'b1, 1'b0, 1'b0);
        repeat (S - 1) cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1);
        n_checks++; if (evt_if.pendingCount !== 4'd15) begin n_fail++; $display("FAIL ovf_full_pop_count: got %0d expected 15", evt_if.pendingCount); end
        n_checks++; if (evt_if.overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_full_pop_flag: got %b expected 0", evt_if.overflow); end
        $display("test_overflow done");
    endtask

    task automatic test_reset_mid();
        apply_reset(1'b1);
        warm();
        for (int t = 0; t < 5; t++) begin
            cycle(1'b1, 1'b0, 1'b0);
            repeat (3) cycle(1'b0, 1'b0, 1'b0);
        end
        repeat (S + 1) cycle(1'b0, 1'b0, 1'b0);
        n_checks++; if (evt_if.pendingCount !== 4'd5) begin n_fail++; $display("FAIL mid_pre: got %0d expected 5", evt_if.pendingCount); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (evt_if.pendingCount !== '0) begin n_fail++; $display("FAIL mid_count: got %0d expected 0", evt_if.pendingCount); end
        n_checks++; if (evt_if.eventValid !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %b expected 0", evt_if.eventValid); end
        n_checks++; if (evt_if.overflow !== 1'b0) begin n_fail++; $display("FAIL mid_ovf: got %b expected 0", evt_if.overflow); end
        n_checks++; if (evt_if.toggleAck !== 1'b0) begin n_fail++; $display("FAIL mid_ack: got %b expected 0", evt_if.toggleAck); end
        toggle_in = ~toggle_in;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cycle(1'b0, 1'b0, 1'b0);
            n_checks++; if (evt_if.pendingCount !== '0) begin n_fail++; $display("FAIL mid_spurious: got %0d expected 0", evt_if.pendingCount); end
        end
        $display("test_reset_mid done");
    endtask

    task automatic test_ack();
        int changes = 0;
        logic prev_ack;
        apply_reset(1'b0);
        warm();
        prev_ack = evt_if.toggleAck;
        for (int t = 0; t < 4; t++) begin
            for (int c = 0; c < 5; c++) begin
                cycle(c == 0, 1'b1, 1'b0);
                if (evt_if.toggleAck !== prev_ack) changes++;
                prev_ack = evt_if.toggleAck;
                n_checks++; if (evt_if.toggleAck !== m_ack) begin n_fail++; $display("FAIL ack_level: got %b expected %b", evt_if.toggleAck, m_ack); end
            end
        end
        repeat (S + 2) cycle(1'b0, 1'b1, 1'b0);
        n_checks++; if (changes != (ACK_EN ? 4 : 0)) begin n_fail++; $display("FAIL ack_changes: got %0d expected %0d", changes, ACK_EN ? 4 : 0); end
        n_checks++; if (evt_if.pendingCount !== '0) begin n_fail++; $display("FAIL ack_drained: got %0d expected 0", evt_if.pendingCount); end
        $display("test_ack done");
    endtask

    task automatic test_random();
        int since = 99;
        bit flip, rdy, clr;
        apply_reset(1'($urandom_range(0, 1)));
        warm();
        for (int i = 0; i < 600; i++) begin
            flip = (since >= S + 1) && ($urandom_range(0, 2) == 0);
            rdy  = (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            clr  = ($urandom_range(0, 15) == 0);
            since = flip ? 1 : since + 1;
            cycle(flip, rdy, clr);
            n_checks++; if (evt_if.pendingCount !== m_count) begin n_fail++; $display("FAIL rnd_count: cycle %0d got %0d expected %0d", i, evt_if.pendingCount, m_count); end
            n_checks++; if (evt_if.eventValid !== (m_count != 0)) begin n_fail++; $display("FAIL rnd_valid: cycle %0d got %b expected %b", i, evt_if.eventValid, m_count != 0); end
            n_checks++; if (evt_if.overflow !== m_ovf) begin n_fail++; $display("FAIL rnd_ovf: cycle %0d got %b expected %b", i, evt_if.overflow, m_ovf); end
            n_checks++; if (evt_if.toggleAck !== m_ack) begin n_fail++; $display("FAIL rnd_ack: cycle %0d got %b expected %b", i, evt_if.toggleAck, m_ack); end
        end
        $display("test_random done");
    endtask

    initial begin
        model_reset();
        m_last = 1'b0;
        test_reset();
        test_latency();
        test_collide();
        test_overflow();
        test_reset_mid();
        test_ack();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
